// File: rtl/fifo_axis_framer.sv
// Drains the sniffer FIFO through a 3-entry prefetch buffer and emits AXI4-Stream frames of
// FRAME_LEN words. A stalled partial frame is closed with tlast after FLUSH_TIMEOUT idle cycles.
module fifo_axis_framer #(
  parameter int DATA_W        = 64,
  parameter int FRAME_LEN     = 256,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [31:0]       frame_cnt,
  output logic [15:0]       flush_cnt
);

  localparam int IDLE_W = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [15:0]       LAST_IDX  = 16'(FRAME_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = (FLUSH_TIMEOUT > 0) ? IDLE_W'(FLUSH_TIMEOUT - 1) : '0;
  localparam bit                FLUSH_ON  = (FLUSH_TIMEOUT != 0);

  logic [DATA_W-1:0] r_buf [3];
  logic [1:0]        r_head;
  logic [1:0]        r_tail;
  logic [1:0]        r_count;
  logic              r_inflight;
  logic [15:0]       r_word_cnt;
  logic [IDLE_W-1:0] r_idle;
  logic              r_flush;
  logic [31:0]       r_frame_cnt;
  logic [15:0]       r_flush_cnt;

  logic [2:0] w_occupancy;
  logic       w_rd_en;
  logic       w_at_last;
  logic       w_tvalid;
  logic       w_tlast;
  logic       w_push;
  logic       w_pop;
  logic       w_idle_cond;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are issued only from registered occupancy so there is no tready-to-rd_en path;
  // the in-flight word always has a free slot when it lands.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_rd_en     = !arst && !fifo_empty && (w_occupancy <= 3'd2);

  // The head is offered only once its tlast is known: either a successor exists (buffered or
  // in flight), it ends the frame by position, or the idle flush has fired.
  assign w_at_last   = (r_word_cnt == LAST_IDX);
  assign w_tvalid    = (r_count != 2'd0) &&
                       ((r_count >= 2'd2) || r_inflight || w_at_last || r_flush);
  assign w_tlast     = w_at_last || r_flush;
  assign w_push      = r_inflight;
  assign w_pop       = w_tvalid && m_axis_tready;
  assign w_idle_cond = FLUSH_ON && (r_count == 2'd1) && !r_inflight && fifo_empty && !w_tvalid;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      // NOTE: the buffer is reset along with the control state so tdata reads 0 during reset;
      // plain storage arrays normally skip reset, but this one drives a port directly.
      for (int i = 0; i < 3; i++) r_buf[i] <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_inflight  <= 1'b0;
      r_word_cnt  <= '0;
      r_idle      <= '0;
      r_flush     <= 1'b0;
      r_frame_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_inflight <= w_rd_en;

      if (w_push) begin
        r_buf[r_tail] <= fifo_dout;
        r_tail        <= next_ptr(r_tail);
      end
      if (w_pop) r_head <= next_ptr(r_head);

      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      if (w_pop) begin
        if (w_tlast) begin
          r_word_cnt  <= '0;
          r_frame_cnt <= r_frame_cnt + 32'd1;
          r_flush     <= 1'b0;
          // A flush that lands on a natural frame boundary is counted as a normal frame.
          if (r_flush && !w_at_last && (r_flush_cnt != 16'hFFFF))
            r_flush_cnt <= r_flush_cnt + 16'd1;
        end else begin
          r_word_cnt <= r_word_cnt + 16'd1;
        end
      end

      if (w_idle_cond) begin
        r_idle <= r_idle + 1'b1;
        if (r_idle == IDLE_LAST) r_flush <= 1'b1;
      end else begin
        r_idle <= '0;
      end
    end
  end

  assign fifo_rd_en    = w_rd_en;
  assign m_axis_tdata  = r_buf[r_head];
  assign m_axis_tvalid = w_tvalid;
  assign m_axis_tlast  = w_tlast;
  assign frame_cnt     = r_frame_cnt;
  assign flush_cnt     = r_flush_cnt;

  // The prefetch issue rule guarantees a landing word never meets a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (arst)
    !(w_push && !w_pop && (r_count == 2'd3)));

endmodule

// File: tb/tb_fifo_axis_framer.sv
// Bench for fifo_axis_framer: a table of streaming cases checked by a beat monitor, plus
// hand-written reset, backpressure and FRAME_LEN=1 sequences.
module tb_fifo_axis_framer;

  localparam int DW = 64;
  localparam int FL = 256;
  localparam int FT = 1024;
  localparam int BUDGET = 20000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic arst;

  // Source FIFO model for the main DUT: standard mode, data one cycle after rd_en.
  logic [DW-1:0] mem [4096];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout = '0;
  logic [DW-1:0] tdata;
  logic          tvalid, tready, tlast;
  logic [31:0]   frame_cnt;
  logic [15:0]   flush_cnt;

  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr[11:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  fifo_axis_framer #(.DATA_W(DW), .FRAME_LEN(FL), .FLUSH_TIMEOUT(FT)) dut (
    .clk(clk), .arst(arst),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
    .frame_cnt(frame_cnt), .flush_cnt(flush_cnt)
  );

  // Second instance with single-word frames.
  logic [DW-1:0] mem1 [16];
  int            wr1 = 0;
  int            rd1 = 0;
  logic          empty1, rd_en1;
  logic [DW-1:0] dout1 = '0;
  logic [DW-1:0] tdata1;
  logic          tvalid1, tlast1;
  logic          tready1 = 1'b1;
  logic [31:0]   frame1;
  logic [15:0]   flush1;

  assign empty1 = (wr1 == rd1);
  always @(posedge clk) begin
    if (rd_en1) begin
      dout1 <= mem1[rd1[3:0]];
      rd1   <= rd1 + 1;
    end
  end

  fifo_axis_framer #(.DATA_W(DW), .FRAME_LEN(1), .FLUSH_TIMEOUT(FT)) dut1 (
    .clk(clk), .arst(arst),
    .fifo_empty(empty1), .fifo_rd_en(rd_en1), .fifo_dout(dout1),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready1), .m_axis_tlast(tlast1),
    .frame_cnt(frame1), .flush_cnt(flush1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int seq);
    return {~32'(seq), 32'(seq)};
  endfunction

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[11:0]] = word_of(wr_ptr);
      wr_ptr++;
    end
  endtask

  // Beat monitor: checks every handshake against the pushed sequence and frame position,
  // and checks that a stalled beat holds its data and tlast.
  int          n_beats  = 0;
  int          beat_seq = 0;
  int          exp_pos  = 0;
  bit          flush_mark [4096];
  logic        hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic        hold_last = 1'b0;

  always @(negedge clk) begin
    logic exp_last;
    if (arst) begin
      beat_seq  = rd_ptr;
      exp_pos   = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_tvalid", tvalid, 1'b1);
        check("hold_tdata", tdata, hold_data);
        check("hold_tlast", tlast, hold_last);
      end
      if (tvalid && tready) begin
        exp_last = (exp_pos == FL - 1) || flush_mark[beat_seq[11:0]];
        check("beat_tdata", tdata, word_of(beat_seq));
        check("beat_tlast", tlast, exp_last);
        exp_pos = exp_last ? 0 : exp_pos + 1;
        beat_seq++;
        n_beats++;
      end
      hold_prev = tvalid && !tready;
      hold_data = tdata;
      hold_last = tlast;
    end
  end

  typedef struct {
    int n_words;     // words pushed at the start
    int n_more;      // words pushed once the last word has idled gap_idle cycles
    int gap_idle;
    int ready_pct;
    int exp_frames;
    int exp_flush;   // 1 when the final word is expected to be closed by timeout
  } case_t;

  case_t cases [4];
  int    exp_frame_total = 0;
  int    exp_flush_total = 0;

  task automatic run_case(input int idx, input case_t c);
    int start  = n_beats;
    int base   = wr_ptr;
    int target = c.n_words + c.n_more;
    int idle = 0, cyc = 0, first_rd = -1, first_v = -1;
    bit gap_ok = 1'b1;
    bit more_done = (c.n_more == 0);
    if (c.exp_flush != 0) flush_mark[(base + target - 1) & 4095] = 1'b1;
    push_words(c.n_words);
    while ((n_beats - start < target) && (cyc < BUDGET)) begin
      tready = ($urandom_range(99) < c.ready_pct);
      #1;
      if (first_rd < 0 && fifo_rd_en) first_rd = cyc;
      if (first_v < 0 && tvalid) first_v = cyc;
      if (first_v >= 0 && !tvalid) gap_ok = 1'b0;
      if (!tvalid && (n_beats - start == c.n_words - 1)) idle++;
      if (!more_done && idle == c.gap_idle) begin
        push_words(c.n_more);
        more_done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("case%0d_beats", idx), n_beats - start, target);
    if (idx == 0) begin
      check("case0_latency", first_v - first_rd, 2);
      check("case0_gap_free", gap_ok, 1'b1);
    end
    if (c.exp_flush != 0) check($sformatf("case%0d_flush_idle", idx), idle, FT);
    if (c.n_more != 0) check($sformatf("case%0d_refill", idx), more_done, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    exp_frame_total += c.exp_frames;
    exp_flush_total += c.exp_flush;
    check($sformatf("case%0d_frame_cnt", idx), frame_cnt, exp_frame_total);
    check($sformatf("case%0d_flush_cnt", idx), flush_cnt, exp_flush_total);
    check($sformatf("case%0d_idle_tvalid", idx), tvalid, 1'b0);
  endtask

  initial begin
    int start, base, cyc, k;

    cases[0] = '{n_words: 512, n_more: 0,   gap_idle: -1,  ready_pct: 100, exp_frames: 2, exp_flush: 0};
    cases[1] = '{n_words: 10,  n_more: 0,   gap_idle: -1,  ready_pct: 100, exp_frames: 1, exp_flush: 1};
    cases[2] = '{n_words: 10,  n_more: 246, gap_idle: 500, ready_pct: 100, exp_frames: 1, exp_flush: 0};
    cases[3] = '{n_words: 600, n_more: 0,   gap_idle: -1,  ready_pct: 30,  exp_frames: 3, exp_flush: 1};

    arst   = 1'b1;
    tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_tdata", tdata, '0);
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_frame_cnt", frame_cnt, '0);
    check("rst_flush_cnt", flush_cnt, '0);
    arst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_case(i, cases[i]);

    // Mid-frame reset under backpressure with the source FIFO still holding words.
    start = n_beats;
    base  = rd_ptr;
    push_words(110);
    tready = 1'b1;
    cyc = 0;
    while ((n_beats - start < 100) && (cyc < 1000)) begin
      @(posedge clk); #1;
      cyc++;
    end
    tready = 1'b0;
    check("pre_reset_beats", n_beats - start, 100);
    repeat (5) @(posedge clk);
    #1;
    check("bp_tvalid", tvalid, 1'b1);
    check("bp_rd_stop", fifo_rd_en, 1'b0);
    check("bp_fetched", rd_ptr - base, 103);
    #2;
    arst = 1'b1;
    #1;
    check("arst_tvalid", tvalid, 1'b0);
    check("arst_tlast", tlast, 1'b0);
    check("arst_tdata", tdata, '0);
    check("arst_rd_en_gated", fifo_rd_en, 1'b0);
    check("arst_frame_cnt", frame_cnt, '0);
    check("arst_flush_cnt", flush_cnt, '0);
    @(negedge clk);
    @(posedge clk); #1;
    arst = 1'b0;
    start = n_beats;
    push_words(256 - (wr_ptr - rd_ptr));
    tready = 1'b1;
    cyc = 0;
    while ((n_beats - start < 256) && (cyc < BUDGET)) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("post_reset_beats", n_beats - start, 256);
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_frame_cnt", frame_cnt, 32'd1);
    check("post_reset_flush_cnt", flush_cnt, 16'd0);

    // FRAME_LEN=1: every word is its own frame.
    for (int i = 0; i < 5; i++) begin
      mem1[wr1[3:0]] = word_of(100 + i);
      wr1++;
    end
    k = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tvalid1 && tready1) begin
        check("fl1_tdata", tdata1, word_of(100 + k));
        check("fl1_tlast", tlast1, 1'b1);
        k++;
      end
    end
    check("fl1_beats", k, 5);
    check("fl1_frame_cnt", frame1, 32'd5);
    check("fl1_flush_cnt", flush1, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
